// File: rtl/return_addr_stack_pkg.sv
// Operation decode for the return address stack.
package return_addr_stack_pkg;

   typedef enum logic [2:0] {
      RAS_IDLE,
      RAS_PUSH,
      RAS_POP,
      RAS_REPLACE,
      RAS_FLUSH
   } ras_op_e;

   // Flush wins; a push+pop on an empty stack degrades to a plain push, a lone pop on empty is a no-op.
   function automatic ras_op_e decode_op(input logic push, input logic pop,
                                         input logic flush, input logic empty);
      ras_op_e op;
      op = RAS_IDLE;
      if (flush)                 op = RAS_FLUSH;
      else if (push && pop)      op = empty ? RAS_PUSH : RAS_REPLACE;
      else if (push)             op = RAS_PUSH;
      else if (pop && !empty)    op = RAS_POP;
      return op;
   endfunction

endpackage : return_addr_stack_pkg

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I datapath types.
package rv32i_types_pkg;

   localparam int unsigned XLEN = 32;

   typedef logic [XLEN-1:0] word_t;

endpackage : rv32i_types_pkg

// File: rtl/return_addr_stack.sv
// Fetch-side return address stack with registered mispredict check and saturating statistics.
module return_addr_stack
   import rv32i_types_pkg::*;
   import return_addr_stack_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic                     push,
   input  word_t                    push_addr,
   input  logic                     pop,
   output logic                     pred_valid,
   output word_t                    pred_addr,
   input  logic                     flush,
   input  logic                     resolve_valid,
   input  word_t                    resolve_pred_addr,
   input  word_t                    resolve_jalr_addr,
   output logic                     mispredict,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CNT_W-1:0]         mispredict_cnt
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned NUM_W = PTR_W + 1;

   typedef logic [PTR_W-1:0] ras_ptr_t;

   word_t            stack_mem [DEPTH];
   ras_ptr_t         tos_q, tos_d;
   logic [NUM_W-1:0] count_q, count_d;
   logic             mispredict_q, mispredict_d;
   logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

   ras_op_e          op_c;
   logic             wr_en_c;
   ras_ptr_t         wr_ptr_c;
   word_t            wr_data_c;

   // Stack pointer, occupancy and entry write control.
   always_comb begin
      tos_d     = tos_q;
      count_d   = count_q;
      wr_en_c   = 1'b0;
      wr_ptr_c  = tos_q;
      wr_data_c = {push_addr[31:1], 1'b0};
      op_c      = decode_op(push, pop, flush, count_q == '0);

      case (op_c)
         RAS_FLUSH: count_d = '0;
         RAS_PUSH: begin
            tos_d    = tos_q + PTR_W'(1);
            wr_ptr_c = tos_q + PTR_W'(1);
            wr_en_c  = 1'b1;
            if (count_q != NUM_W'(DEPTH)) count_d = count_q + NUM_W'(1);
         end
         RAS_POP: begin
            tos_d   = tos_q - PTR_W'(1);
            count_d = count_q - NUM_W'(1);
         end
         RAS_REPLACE: wr_en_c = 1'b1;
         default: ;
      endcase
   end

   // Mispredict detection is independent of flush.
   always_comb begin
      mispredict_d = resolve_valid && (resolve_pred_addr != resolve_jalr_addr);
      mis_cnt_d    = mis_cnt_q;
      if (mispredict_d && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         tos_q        <= '0;
         count_q      <= '0;
         mispredict_q <= 1'b0;
         mis_cnt_q    <= '0;
      end else begin
         tos_q        <= tos_d;
         count_q      <= count_d;
         mispredict_q <= mispredict_d;
         mis_cnt_q    <= mis_cnt_d;
      end
   end

   // Entry storage carries no reset; validity is tracked by count_q.
   always_ff @(posedge CLK) begin
      if (wr_en_c) stack_mem[wr_ptr_c] <= wr_data_c;
   end

   assign pred_addr      = stack_mem[tos_q];
   assign pred_valid     = (count_q != '0);
   assign count          = count_q;
   assign mispredict     = mispredict_q;
   assign mispredict_cnt = mis_cnt_q;

endmodule : return_addr_stack

// File: tb/tb_return_addr_stack.sv
// Directed and random checks of return_addr_stack against a queue-based stack model.
module tb_return_addr_stack;
   import rv32i_types_pkg::*;

   localparam int unsigned DEPTH   = 8;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned NUM_W   = $clog2(DEPTH) + 1;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic             CLK = 1'b0;
   logic             nRST;
   logic             push, pop, flush, resolve_valid;
   word_t            push_addr, resolve_pred_addr, resolve_jalr_addr;
   logic             pred_valid, mispredict;
   word_t            pred_addr;
   logic [NUM_W-1:0] count;
   logic [CNT_W-1:0] mispredict_cnt;

   return_addr_stack #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .CLK               (CLK),
      .nRST              (nRST),
      .push              (push),
      .push_addr         (push_addr),
      .pop               (pop),
      .pred_valid        (pred_valid),
      .pred_addr         (pred_addr),
      .flush             (flush),
      .resolve_valid     (resolve_valid),
      .resolve_pred_addr (resolve_pred_addr),
      .resolve_jalr_addr (resolve_jalr_addr),
      .mispredict        (mispredict),
      .count             (count),
      .mispredict_cnt    (mispredict_cnt)
   );

   always #5 CLK = ~CLK;

   word_t       model_q[$];
   int unsigned model_cnt;
   logic        model_mis;
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".valid"}, 32'(pred_valid), 32'(model_q.size() != 0));
      if (model_q.size() != 0) check({tag, ".addr"}, pred_addr, model_q[model_q.size()-1]);
      check({tag, ".count"}, 32'(count), 32'(model_q.size()));
      check({tag, ".mis"}, 32'(mispredict), 32'(model_mis));
      check({tag, ".mcnt"}, 32'(mispredict_cnt), model_cnt);
   endtask

   task automatic idle_inputs();
      push = 1'b0; pop = 1'b0; flush = 1'b0; resolve_valid = 1'b0;
      push_addr = '0; resolve_pred_addr = '0; resolve_jalr_addr = '0;
   endtask

   // One clock with the given inputs; the model follows the stack rules directly.
   task automatic step(input logic ps, input word_t pa, input logic pp, input logic fl,
                       input logic rv, input word_t rp, input word_t rj, input string tag);
      push = ps; push_addr = pa; pop = pp; flush = fl;
      resolve_valid = rv; resolve_pred_addr = rp; resolve_jalr_addr = rj;
      @(posedge CLK);
      if (fl) model_q.delete();
      else if (ps && pp && model_q.size() != 0) model_q[model_q.size()-1] = {pa[31:1], 1'b0};
      else if (ps) begin
         if (model_q.size() == DEPTH) void'(model_q.pop_front());
         model_q.push_back({pa[31:1], 1'b0});
      end else if (pp && model_q.size() != 0) void'(model_q.pop_back());
      model_mis = rv && (rp != rj);
      if (model_mis && model_cnt != CNT_MAX) model_cnt++;
      #1;
      idle_inputs();
      check_all(tag);
   endtask

   task automatic do_push(input word_t a, input string tag);
      step(1'b1, a, 1'b0, 1'b0, 1'b0, '0, '0, tag);
   endtask

   task automatic do_pop(input string tag);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0, tag);
   endtask

   task automatic do_resolve(input word_t p, input word_t a, input string tag);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, p, a, tag);
   endtask

   initial begin
      idle_inputs();
      nRST = 1'b0;
      model_cnt = 0;
      model_mis = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK) nRST = 1'b1;
      check_all("reset");

      // Underflow leaves everything alone.
      do_pop("underflow");

      do_push(32'h100, "p100");
      do_push(32'h204, "p204");
      do_push(32'h308, "p308");
      check("three.addr", pred_addr, 32'h308);
      check("three.count", 32'(count), 32'd3);
      do_pop("pop1");
      check("pop1.addr", pred_addr, 32'h204);
      do_pop("pop2");
      check("pop2.addr", pred_addr, 32'h100);
      do_pop("pop3");
      check("pop3.valid", 32'(pred_valid), 32'd0);

      // Overflow wraps onto the oldest entries.
      for (int i = 0; i < 10; i++) do_push(32'h1000 + 32'(4 * i), "ovf.push");
      check("ovf.count", 32'(count), 32'd8);
      check("ovf.addr", pred_addr, 32'h1024);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) check("ovf.last", pred_addr, 32'h1008);
         do_pop("ovf.pop");
      end
      check("ovf.empty", 32'(pred_valid), 32'd0);

      // Coroutine replace clears bit 0.
      do_push(32'h40, "p40");
      do_push(32'h80, "p80");
      step(1'b1, 32'hC1, 1'b1, 1'b0, 1'b0, '0, '0, "replace");
      check("replace.addr", pred_addr, 32'hC0);
      check("replace.count", 32'(count), 32'd2);
      do_pop("replace.pop");
      check("replace.pop.addr", pred_addr, 32'h40);
      do_pop("drain");

      // Flush beats a same-cycle push.
      do_push(32'h500, "p500");
      step(1'b1, 32'h600, 1'b0, 1'b1, 1'b0, '0, '0, "flush");
      check("flush.count", 32'(count), 32'd0);

      // Mispredict pulse, match, and flush not suppressing resolution.
      do_resolve(32'h200, 32'h204, "mis");
      check("mis.pulse", 32'(mispredict), 32'd1);
      check("mis.cnt", 32'(mispredict_cnt), 32'd1);
      do_resolve(32'h300, 32'h300, "match");
      check("match.pulse", 32'(mispredict), 32'd0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h14, "mis_flush");
      check("mis_flush.pulse", 32'(mispredict), 32'd1);

      // Counter saturation.
      for (int i = 0; i < 16; i++) do_resolve(32'h0, 32'(i + 1), "sat");
      check("sat.cnt", 32'(mispredict_cnt), CNT_MAX);

      // Reset mid-operation drops the pending pulse.
      do_push(32'h700, "pre_rst");
      do_resolve(32'h1, 32'h2, "pre_rst.mis");
      #1 nRST = 1'b0;
      #1;
      model_q.delete();
      model_cnt = 0;
      model_mis = 1'b0;
      check_all("midrst");
      @(negedge CLK) nRST = 1'b1;

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         logic  ps, pp, fl, rv;
         word_t pa, rp, rj;
         ps = 1'($urandom_range(0, 1));
         pp = 1'($urandom_range(0, 1));
         fl = ($urandom_range(0, 15) == 0);
         rv = 1'($urandom_range(0, 1));
         pa = $urandom;
         rp = $urandom;
         rj = ($urandom_range(0, 1) != 0) ? rp : (rp ^ 32'(1 << $urandom_range(0, 31)));
         step(ps, pa, pp, fl, rv, rp, rj, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_return_addr_stack

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Fetch-side predictor for JALR return targets; the predicting end of the jump-target path whose resolving end is the execute-stage jump address calculation.
- Calls push the return address; returns pop a predicted target that fetch uses before execute resolves the real jalr_addr.
- Execute feeds back the resolved target; the block flags mispredicts and keeps a saturating mispredict count for performance counters.

Parameters:
- DEPTH, 8, number of stack entries (power of two, >= 2).
- CNT_W, 16, width of the mispredict statistics counter.

Ports:
- CLK  input  1  system clock.
- nRST  input  1  asynchronous active-low reset.
- push  input  1  fetch decoded a call (JAL/JALR with rd = x1/x5).
- push_addr  input  32  return address (PC+4), word_t.
- pop  input  1  fetch decoded a return (JALR with rs1 = x1/x5).
- pred_valid  output  1  stack non-empty; pred_addr usable.
- pred_addr  output  32  predicted return target (top of stack).
- flush  input  1  pipeline flush; discards all entries.
- resolve_valid  input  1  execute resolved a RAS-predicted JALR this cycle.
- resolve_pred_addr  input  32  prediction carried down the pipe with that JALR.
- resolve_jalr_addr  input  32  actual target from the jump calculation block.
- mispredict  output  1  one-cycle pulse: prediction was wrong.
- count  output  $clog2(DEPTH)+1  valid entries.
- mispredict_cnt  output  CNT_W  saturating mispredict count.

Behaviour:
- Reset (nRST low, asynchronous): tos = 0, count = 0, mispredict = 0, mispredict_cnt = 0. Entry storage is not reset. pred_valid = 0.
- Storage: circular buffer of DEPTH word_t entries. tos points at the top entry. pointer arithmetic is modulo DEPTH.
- pred_addr = stack[tos] and pred_valid = (count != 0), both combinational from registers. pred_addr is don't-care when pred_valid = 0.
- Push only: tos <= tos+1 and stack[tos+1] <= {push_addr[31:1],1'b0}. count increments, saturating at DEPTH.
- Push when full: overwrites the oldest entry (wrap-around); count stays DEPTH.
- Pop only:
  - count != 0: tos <= tos-1, count decrements. The popped entry is not cleared.
  - count == 0 (underflow): no state change.
- Push and pop in the same cycle (coroutine JALR):
  - count != 0: replace the top entry in place; tos and count unchanged.
  - count == 0: behaves as push only.
- Flush: count <= 0, tos unchanged. Flush has priority over push/pop in the same cycle; both are ignored.
- Mispredict check:
  - Registered. In the cycle after resolve_valid = 1 with resolve_pred_addr != resolve_jalr_addr, mispredict = 1 for exactly one cycle. Otherwise mispredict = 0.
  - mispredict_cnt increments on that same edge and saturates at all-ones.
  - Resolution is independent of flush; a flush in the same cycle does not suppress the check.
- The block never initiates a redirect itself; the hazard unit consumes mispredict.
- Reset mid-operation: all state returns to reset values immediately; pending mispredict pulse is dropped.

Decomposition:
- Uses word_t from rv32i_types_pkg.
- Add a ras_ptr_t typedef (logic [$clog2(DEPTH)-1:0]) to that package only if other predictors share it. Otherwise keep it local.
- No sub-module. Optionally a ras_stat_counter (saturating counter) sub-module if the performance-counter block reuses it.
- Pairs with a future ras_if interface bundling push/pop/pred and resolve signals, with fetch and execute modports.

Test Plan:
- Reset then pop -> pred_valid = 0, count = 0; after the pop, count still 0 and tos unchanged.
- Push 0x100, 0x204, 0x308 -> pred_addr = 0x308, count = 3. Pop -> pred_addr = 0x204. Pop -> 0x100. Pop -> pred_valid = 0.
- DEPTH = 8: push 0x1000..0x1024 (10 words, step 4) -> count = 8, pred_addr = 0x1024. Pop 8 times -> last valid value 0x1008, then empty.
- Push 0x40, 0x80; push+pop with push_addr 0xC1 -> count = 2, pred_addr = 0xC0 (bit 0 cleared). Pop -> 0x40.
- Push 0x500, then flush asserted together with push 0x600 -> count = 0, pred_valid = 0.
- resolve_valid with pred 0x200 vs actual 0x204 -> mispredict = 1 next cycle only, mispredict_cnt = 1. Matching addresses -> no pulse. Preset the counter near 0xFFFF -> it saturates at 0xFFFF.
